// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//   Hazard/stall controller for a five-stage pipeline with a multi-cycle
//   HI/LO multiply/divide unit. Detects register read-after-write hazards
//   between the instruction in D and the producers in E and M (Tuse/Tnew
//   model), stalls D instructions that touch HI/LO while the unit is busy,
//   tracks the unit's busy time, and counts stalled cycles (saturating).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rs_D/rt_D  in   source register fields of the D instruction
//   tuse_rs/rt in   cycles until D needs rs/rt (3 = not used)
//   A3_E/A3_M  in   destination register of the E/M instruction
//   tnew_E/M   in   cycles until the E/M result is available
//   md_D       in   D instruction uses the HI/LO unit
//   start_E    in   mult/multu/div/divu in E
//   is_div_E   in   the E start is a divide
//   en_F/en_D  out  PC and IF/ID register enables (low while stalling)
//   flush_E    out  insert a bubble into E
//   stall      out  stall asserted this cycle
//   busy       out  HI/LO unit busy
//   stall_cnt  out  saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_D,
  input  logic        start_E,
  input  logic        is_div_E,
  output logic        en_F,
  output logic        en_D,
  output logic        flush_E,
  output logic        stall,
  output logic        busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt_r;
  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;

  // Register 0 is hardwired zero, so it never carries a dependency.
  // tuse == 3 marks an operand the instruction does not read.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == a3_e) && (tnew_e > tuse);
    hit_m = (src == a3_m) && (tnew_m > tuse);
    return (tuse != 2'd3) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- combinational hazard detection (same-cycle stall) ----
  always_comb begin
    stall_rs = raw_hazard(rs_D, tuse_rs, A3_E, tnew_E, A3_M, tnew_M);
    stall_rt = raw_hazard(rt_D, tuse_rt, A3_E, tnew_E, A3_M, tnew_M);
    // start_E covers the cycle before busy rises, since busy is registered.
    stall_md = md_D && (busy || start_E);
    stall    = stall_rs || stall_rt || stall_md;
    en_F     = ~stall;
    en_D     = ~stall;
    flush_E  = stall;
  end

  // busy comes only from registered state; no path from start_E.
  assign busy      = (md_cnt != 4'd0);
  assign stall_cnt = stall_cnt_r;

  // ---- HI/LO busy counter: a start is ignored while a count is running ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end else if (start_E) begin
      md_cnt <= is_div_E ? DIV_CYC : MULT_CYC;
    end
  end

  // ---- stalled-cycle counter: one increment per stalled edge ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall) begin
      stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_D, rt_D, A3_E, A3_M;
  logic [1:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
  logic        md_D, start_E, is_div_E;
  logic        en_F, en_D, flush_E, stall, busy;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  stall_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rs_D     (rs_D),
    .rt_D     (rt_D),
    .tuse_rs  (tuse_rs),
    .tuse_rt  (tuse_rt),
    .A3_E     (A3_E),
    .tnew_E   (tnew_E),
    .A3_M     (A3_M),
    .tnew_M   (tnew_M),
    .md_D     (md_D),
    .start_E  (start_E),
    .is_div_E (is_div_E),
    .en_F     (en_F),
    .en_D     (en_D),
    .flush_E  (flush_E),
    .stall    (stall),
    .busy     (busy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; tuse_rs = 2'd3; tuse_rt = 2'd3;
    A3_E = 0; tnew_E = 0; A3_M = 0; tnew_M = 0;
    md_D = 0; start_E = 0; is_div_E = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #3;
    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_enF", {31'd0, en_F}, 32'd1);
    // Hazard logic remains live during reset, but nothing is counted
    rs_D = 5; tuse_rs = 0; A3_E = 5; tnew_E = 2;
    #1;
    chk("rst_comb_stall", {31'd0, stall}, 32'd1);
    chk("rst_comb_flush", {31'd0, flush_E}, 32'd1);
    step();
    chk("rst_cnt_hold", stall_cnt, 32'd0);

    // Release; same load-use hazard counts on the very next edge
    reset = 1'b1;
    #1;
    chk("lu_a_stall", {31'd0, stall}, 32'd1);
    chk("lu_a_enF", {31'd0, en_F}, 32'd0);
    chk("lu_a_enD", {31'd0, en_D}, 32'd0);
    chk("lu_a_flush", {31'd0, flush_E}, 32'd1);
    step();
    chk("lu_a_cnt", stall_cnt, 32'd1);
    A3_E = 0; tnew_E = 0; A3_M = 5; tnew_M = 1;
    #1;
    chk("lu_b_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_b_cnt", stall_cnt, 32'd2);
    tnew_M = 0;
    #1;
    chk("lu_c_stall", {31'd0, stall}, 32'd0);
    chk("lu_c_enF", {31'd0, en_F}, 32'd1);
    step();
    chk("lu_c_cnt", stall_cnt, 32'd2);

    // rs not read: no stall even with matching producer
    tuse_rs = 3; A3_E = 5; tnew_E = 2; A3_M = 0;
    #1;
    chk("tuse3_stall", {31'd0, stall}, 32'd0);
    // rt hazard, then tnew equal to tuse (no stall)
    clear_inputs();
    rt_D = 7; tuse_rt = 1; A3_E = 7; tnew_E = 2;
    #1;
    chk("rt_stall", {31'd0, stall}, 32'd1);
    step();
    chk("rt_cnt", stall_cnt, 32'd3);
    tnew_E = 1;
    #1;
    chk("rt_eq_nostall", {31'd0, stall}, 32'd0);
    step();

    // Zero register
    clear_inputs();
    tuse_rs = 0; tuse_rt = 0; A3_E = 0; tnew_E = 2; A3_M = 0; tnew_M = 3;
    #1;
    chk("zero_stall", {31'd0, stall}, 32'd0);
    step();
    chk("zero_cnt", stall_cnt, 32'd3);

    // Simultaneous rs and rt hazards count once
    clear_inputs();
    rs_D = 4; rt_D = 6; tuse_rs = 0; tuse_rt = 0;
    A3_E = 4; tnew_E = 1; A3_M = 6; tnew_M = 2;
    #1;
    chk("dual_stall", {31'd0, stall}, 32'd1);
    step();
    chk("dual_cnt", stall_cnt, 32'd4);

    // Mult then mflo: stall cycles 0..5, free at 6
    clear_inputs();
    start_E = 1; md_D = 1;
    #1;
    chk("mul_c0_stall", {31'd0, stall}, 32'd1);
    chk("mul_c0_busy", {31'd0, busy}, 32'd0);
    step();
    start_E = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("mul_c%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mul_c%0d_stall", i), {31'd0, stall}, 32'd1);
      step();
    end
    #1;
    chk("mul_c6_busy", {31'd0, busy}, 32'd0);
    chk("mul_c6_stall", {31'd0, stall}, 32'd0);
    chk("mul_cnt", stall_cnt, 32'd10);

    // Div: busy 1..10, restart at cycle 3 ignored
    md_D = 0; start_E = 1; is_div_E = 1;
    #1;
    chk("div_c0_busy", {31'd0, busy}, 32'd0);
    step();
    for (int i = 1; i <= 10; i++) begin
      start_E = (i == 3); is_div_E = 0;
      #1;
      chk($sformatf("div_c%0d_busy", i), {31'd0, busy}, 32'd1);
      step();
    end
    start_E = 0;
    #1;
    chk("div_c11_busy", {31'd0, busy}, 32'd0);
    chk("div_cnt", stall_cnt, 32'd10);

    // Reset mid-div
    start_E = 1; is_div_E = 1;
    step();
    start_E = 0; is_div_E = 0;
    step(); step(); step();
    chk("rdiv_c4_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rdiv_busy_async", {31'd0, busy}, 32'd0);
    chk("rdiv_cnt_async", stall_cnt, 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("rdiv_rel_busy", {31'd0, busy}, 32'd0);
    step();
    chk("rdiv_rel2_busy", {31'd0, busy}, 32'd0);
    // A start right after release is taken at the next edge
    start_E = 1; is_div_E = 0;
    step();
    start_E = 0;
    chk("rdiv_restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("rdiv_restart_done", {31'd0, busy}, 32'd0);

    // Saturation from FFFFFFFE under continuous stall
    dut.stall_cnt_r = 32'hFFFF_FFFE;
    rs_D = 9; tuse_rs = 0; A3_E = 9; tnew_E = 1;
    #1;
    chk("sat_pre", stall_cnt, 32'hFFFF_FFFE);
    step();
    chk("sat_e1", stall_cnt, 32'hFFFF_FFFF);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("sat_e%0d", i), stall_cnt, 32'hFFFF_FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The block SHALL provide the following ports, one per line as name, direction, width, meaning, in this order:
  clk  in  1  system clock, all state updates on rising edge
  reset  in  1  asynchronous, active-low reset: state clears immediately when reset=0
  rs_D  in  5  rs field of instruction in D
  rt_D  in  5  rt field of instruction in D
  tuse_rs  in  2  cycles until D instruction needs rs (3 = not used)
  tuse_rt  in  2  cycles until D instruction needs rt (3 = not used)
  A3_E  in  5  destination register of instruction in E
  tnew_E  in  2  cycles until E result is available
  A3_M  in  5  destination register of instruction in M
  tnew_M  in  2  cycles until M result is available
  md_D  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
  start_E  in  1  mult/multu/div/divu currently in E
  is_div_E  in  1  the E start is a divide (qualifies start_E)
  en_F  out  1  PC register enable
  en_D  out  1  IF/ID register enable
  flush_E  out  1  load bubble (all-zero instruction) into E
  stall  out  1  stall asserted this cycle
  busy  out  1  HI/LO unit busy
  stall_cnt  out  32  total stalled cycles since reset

Function
REQ-002 stall_rs SHALL be 1 iff tuse_rs!=3, rs_D!=0, and ((rs_D==A3_E and tnew_E>tuse_rs) or (rs_D==A3_M and tnew_M>tuse_rs)).
REQ-003 stall_rt SHALL be defined identically using rt_D and tuse_rt.
REQ-004 stall_md SHALL be 1 iff md_D=1 and (busy=1 or start_E=1).
REQ-005 stall SHALL equal stall_rs | stall_rt | stall_md, combinational, same cycle.
REQ-006 en_F and en_D SHALL equal ~stall; flush_E SHALL equal stall.
REQ-007 A 4-bit counter md_cnt SHALL load 5 (start_E=1, is_div_E=0) or 10 (start_E=1, is_div_E=1) on the rising edge ending the cycle in which start_E=1 and md_cnt==0.
REQ-008 When md_cnt!=0, md_cnt SHALL decrement by 1 each edge, and start_E SHALL be ignored (no reload).
REQ-009 busy SHALL equal (md_cnt!=0), registered-state derived, with no combinational path from start_E.
REQ-010 For a mult entering E in cycle t: busy=1 in cycles t+1..t+5 and 0 in t+6; for a div: busy=1 in t+1..t+10.
REQ-011 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-012 Register 0 SHALL never cause a stall, whatever A3_E/A3_M/tnew values are presented.
REQ-013 Simultaneous hazard sources SHALL produce a single stall per cycle, and stall_cnt SHALL increment by 1 only.
REQ-014 The block SHALL hold no state besides md_cnt and stall_cnt.

Reset
REQ-015 While reset=0, md_cnt=0 and stall_cnt=0 asynchronously; busy=0.
REQ-016 Outputs en_F, en_D, flush_E and stall SHALL follow REQ-005/006 combinationally during reset, using busy=0.
REQ-017 Reset asserted mid-operation (md_cnt!=0) SHALL abort the count immediately; after release, md_cnt=0 until the next start_E.
REQ-018 Release of reset SHALL take effect at the next rising edge of clk with no extra wait cycles.

Verification
REQ-019 Load-use: rs_D=5, tuse_rs=0, A3_E=5, tnew_E=2 -> stall=1, en_F=en_D=0, flush_E=1; the next cycle A3_M=5, tnew_M=1 -> stall=1; the cycle after that A3_M=5, tnew_M=0 -> stall=0.
REQ-020 Zero register: rs_D=0, A3_E=0, tnew_E=2, tuse_rs=0 -> stall=0, stall_cnt unchanged.
REQ-021 Mult then mflo: start_E=1, is_div_E=0 in cycle 0, md_D=1 held -> stall=1 in cycles 0..5 and 0 in cycle 6; stall_cnt=6.
REQ-022 Div: start_E=1, is_div_E=1 at cycle 0 -> busy=1 in cycles 1..10 and 0 in cycle 11; a second start_E at cycle 3 leaves the count unchanged.
REQ-023 Reset mid-div: reset=0 at cycle 4 -> busy=0 and stall_cnt=0 immediately, with no clock edge required.
REQ-024 Saturation: force stall=1 continuously from stall_cnt=32'hFFFFFFFE -> stall_cnt reads 32'hFFFFFFFF on the next edge and stays there on all following edges.
